// File: rtl/core_pkg.sv
// Shared definitions for the core execution units.
// Holds operand width and the multiply/divide op and state encodings.
package core_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } muldiv_state_e;

endpackage

// File: rtl/core_muldiv_unit.sv
// Iterative RV32M multiply/divide unit, fixed XLEN+1 cycle latency.
// One shared XLEN+1-bit adder does shift-add and restoring subtract.
module core_muldiv_unit
  import core_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_muldiv_start,
  input  logic [3:0]      i_muldiv_alucontrol,
  input  logic [XLEN-1:0] i_muldiv_rs1,
  input  logic [XLEN-1:0] i_muldiv_rs2,
  input  logic [4:0]      i_muldiv_rd,
  input  logic            i_muldiv_flush,
  output logic            o_muldiv_busy,
  output logic            o_muldiv_valid,
  output logic [XLEN-1:0] o_muldiv_result,
  output logic [4:0]      o_muldiv_rd
);

  localparam int CW = $clog2(XLEN);

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_q, op_in;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] opnd_q, hi_q, lo_q;
  logic [XLEN-1:0] hi_d, lo_d;
  logic            neg_q, bzero_q;
  logic            sgn_a, sgn_b;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            is_mul, sub, cout;
  logic [XLEN:0]   add_a, add_b, sum;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quot_s, rem_s, res_d;
  logic            accept, last;

  assign accept = (state_q == ST_IDLE) && i_muldiv_start
                  && !i_muldiv_flush;
  assign last   = (state_q == ST_CALC)
                  && (cnt_q == CW'(XLEN - 1));

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state; flush always returns to idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (i_muldiv_start) state_d = ST_CALC;
      ST_CALC: if (last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (i_muldiv_flush) state_d = ST_IDLE;
  end

  // Operand signedness and magnitudes at accept
  always_comb begin
    op_in = muldiv_op_e'(i_muldiv_alucontrol[2:0]);
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    unique case (op_in)
      OP_MUL, OP_MULH,
      OP_DIV, OP_REM: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      OP_MULHSU: sgn_a = 1'b1;
      default: ;
    endcase
    a_neg = sgn_a & i_muldiv_rs1[XLEN-1];
    b_neg = sgn_b & i_muldiv_rs2[XLEN-1];
    a_mag = a_neg ? -i_muldiv_rs1 : i_muldiv_rs1;
    b_mag = b_neg ? -i_muldiv_rs2 : i_muldiv_rs2;
  end

  // One iteration step through the shared adder
  always_comb begin
    is_mul = ~op_q[2];
    sub    = ~is_mul;
    add_a  = is_mul ? {1'b0, hi_q}
                    : {hi_q, lo_q[XLEN-1]};
    add_b  = (is_mul && !lo_q[0]) ? '0
                                  : {1'b0, opnd_q};
    {cout, sum} = {1'b0, add_a}
                + {1'b0, sub ? ~add_b : add_b}
                + {{(XLEN+1){1'b0}}, sub};
    if (is_mul) begin
      hi_d = sum[XLEN:1];
      lo_d = {sum[0], lo_q[XLEN-1:1]};
    end else begin
      hi_d = cout ? sum[XLEN-1:0] : add_a[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], cout};
    end
  end

  // Sign fix-up and result selection on the final step
  always_comb begin
    prod   = {hi_d, lo_d};
    prod_s = neg_q ? -prod : prod;
    quot_s = neg_q ? -lo_d : lo_d;
    rem_s  = neg_q ? -hi_d : hi_d;
    unique case (op_q)
      OP_MUL:  res_d = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU,
      OP_MULHU: res_d = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:
        res_d = bzero_q ? '1 : quot_s;
      default: res_d = rem_s;
    endcase
  end

  // Datapath registers: load on accept, iterate in CALC
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q    <= OP_MUL;
      rd_q    <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      bzero_q <= 1'b0;
    end else if (accept) begin
      op_q    <= op_in;
      rd_q    <= i_muldiv_rd;
      opnd_q  <= op_in[2] ? b_mag : a_mag;
      lo_q    <= op_in[2] ? a_mag : b_mag;
      hi_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= (op_in[2] & op_in[1]) ? a_neg
                                       : a_neg ^ b_neg;
      bzero_q <= (i_muldiv_rs2 == '0);
    end else if (state_q == ST_CALC) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Registered outputs; result and tag change only on a strobe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_muldiv_busy   <= 1'b0;
      o_muldiv_valid  <= 1'b0;
      o_muldiv_result <= '0;
      o_muldiv_rd     <= '0;
    end else begin
      o_muldiv_busy  <= (state_d != ST_IDLE);
      o_muldiv_valid <= (state_d == ST_DONE);
      if (state_d == ST_DONE) begin
        o_muldiv_result <= res_d;
        o_muldiv_rd     <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_core_muldiv_unit.sv
// Randomized self-checking bench for core_muldiv_unit.
// Results compared against a 64-bit arithmetic reference model.
module tb_core_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  alu;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        flush;
  logic        busy, valid;
  logic [31:0] result;
  logic [4:0]  rd_o;

  int checks;
  int failures;
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  core_muldiv_unit dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_muldiv_start      (start),
    .i_muldiv_alucontrol (alu),
    .i_muldiv_rs1        (rs1),
    .i_muldiv_rs2        (rs2),
    .i_muldiv_rd         (rd),
    .i_muldiv_flush      (flush),
    .o_muldiv_busy       (busy),
    .o_muldiv_valid      (valid),
    .o_muldiv_result     (result),
    .o_muldiv_rd         (rd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_fn(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    r  = '0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin up = ua * ub; r = up[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          r = 32'h8000_0000;
        else r = 32'(sa / sb);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          r = 32'h0;
        else r = 32'(sa % sb);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic drive(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] t);
    alu = {1'($urandom), op};
    rs1 = a;
    rs2 = b;
    rd  = t;
  endtask

  // One full operation: latency, busy window, result, tag, hold
  task automatic run_op(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] t);
    logic [31:0] exp;
    logic [31:0] got;
    logic [4:0]  got_rd;
    int vcyc;
    logic busy_ok;
    exp = ref_fn(op, a, b);
    @(negedge clk);
    start = 1'b1;
    drive(op, a, b, t);
    @(negedge clk);
    start = 1'b0;
    drive(3'($urandom), $urandom, $urandom, 5'($urandom));
    vcyc = -1;
    busy_ok = 1'b1;
    got = '0;
    got_rd = '0;
    for (int c = 1; c <= 36; c++) begin
      if (c <= 33 && !busy) busy_ok = 1'b0;
      if (c >= 34 && busy) busy_ok = 1'b0;
      if (valid) begin
        if (vcyc < 0) begin
          vcyc = c;
          got = result;
          got_rd = rd_o;
        end else begin
          vcyc = 1000;
        end
      end
      if (c < 36) @(negedge clk);
    end
    chk($sformatf("lat op%0d", op), 32'(vcyc), 32'd33);
    chk($sformatf("res op%0d a=%h b=%h", op, a, b), got, exp);
    chk("rd", {27'd0, got_rd}, {27'd0, t});
    chk("busy window", {31'd0, busy_ok}, 32'd1);
    chk("hold", result, exp);
    last_res = exp;
    last_rd  = t;
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0]  op;
    logic        bad;
    int vcyc;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    alu = '0;
    rs1 = '0;
    rs2 = '0;
    rd = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst valid", {31'd0, valid}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst rd", {27'd0, rd_o}, 32'd0);
    rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd17);
    chk("mul -21", last_res, 32'hFFFF_FFEB);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run_op(3'd5, 32'd100, 32'd7, 5'd6);
    run_op(3'd7, 32'd100, 32'd7, 5'd7);
    run_op(3'd4, 32'd5, 32'd0, 5'd8);
    run_op(3'd7, 32'd5, 32'd0, 5'd9);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd10);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      else if ($urandom_range(0, 3) == 0)
        b = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      run_op(op, a, b, 5'($urandom));
    end

    // Start while busy, at cycles 5 and 33, must be ignored
    @(negedge clk);
    start = 1'b1;
    drive(3'd5, 32'd100, 32'd7, 5'd3);
    @(negedge clk);
    start = 1'b0;
    vcyc = -1;
    bad = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      if (valid && vcyc < 0) begin
        vcyc = c;
        chk("busy-start res", result, 32'd14);
        chk("busy-start rd", {27'd0, rd_o}, 32'd3);
      end
      if (c >= 34 && busy) bad = 1'b1;
      start = (c == 5 || c == 33);
      if (start) drive(3'd0, 32'd3, 32'd4, 5'd9);
      if (c < 36) @(negedge clk);
    end
    start = 1'b0;
    chk("busy-start lat", 32'(vcyc), 32'd33);
    chk("busy-start idle", {31'd0, bad}, 32'd0);
    last_res = 32'd14;
    last_rd = 5'd3;

    // Flush at cycle 10, new request at cycle 11
    @(negedge clk);
    start = 1'b1;
    drive(3'd0, 32'd1234, 32'd5678, 5'd5);
    @(negedge clk);
    start = 1'b0;
    vcyc = -1;
    bad = 1'b0;
    for (int c = 1; c <= 46; c++) begin
      if (valid && vcyc < 0) vcyc = c;
      if (c == 11) begin
        chk("flush busy", {31'd0, busy}, 32'd0);
        chk("flush res keep", result, last_res);
        chk("flush rd keep", {27'd0, rd_o}, {27'd0, last_rd});
      end
      if (c == 44) begin
        chk("post-flush res", result, 32'd2);
        chk("post-flush rd", {27'd0, rd_o}, 32'd7);
      end
      flush = (c == 10);
      start = (c == 11);
      if (start) drive(3'd7, 32'd100, 32'd7, 5'd7);
      if (c < 46) @(negedge clk);
    end
    start = 1'b0;
    flush = 1'b0;
    chk("flush lat", 32'(vcyc), 32'd44);
    last_res = 32'd2;
    last_rd = 5'd7;

    // Flush and start together in idle: request dropped
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    drive(3'd0, 32'd2, 32'd3, 5'd1);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("flush+start busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("flush+start res", result, last_res);

    // Reset at cycle 20 of a divide
    @(negedge clk);
    start = 1'b1;
    drive(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd11);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid-rst busy", {31'd0, busy}, 32'd0);
    chk("mid-rst valid", {31'd0, valid}, 32'd0);
    chk("mid-rst result", result, 32'd0);
    chk("mid-rst rd", {27'd0, rd_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (valid) bad = 1'b1;
    end
    chk("no valid after rst", {31'd0, bad}, 32'd0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
